// File: rtl/snk68_rom_pkg.sv
// Shared types and default address map for the ROM fetch arbiter.
package snk68_rom_pkg;

  typedef enum logic {
    REQ_M68K = 1'b0,
    REQ_Z80  = 1'b1
  } req_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [23:0] ROM_BASE_DEF      = 24'h000000;
  localparam logic [23:0] M68K_ROM2_OFS_DEF = 24'h040000;
  localparam logic [23:0] Z80_ROM_OFS_DEF   = 24'h080000;

  // Round-robin pick: on a tie the requester that was not granted last wins.
  function automatic req_e rr_pick(input logic m_pend, input logic z_pend, input req_e last);
    if (m_pend && z_pend) return (last == REQ_Z80) ? REQ_M68K : REQ_Z80;
    else if (z_pend)      return REQ_Z80;
    else                  return REQ_M68K;
  endfunction

endpackage

// File: rtl/rom_fetch_arbiter_req_port.sv
// One requester port of the ROM fetch arbiter: select edge detect, pending
// flag, address/lane latch, abort tracking and the valid/dout register.
// Optional line buffer (last word + tag) when ROM_LINE_BUF_EN is defined.
module rom_req_port #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_i,
  input  logic [23:0]   addr_i,
  input  logic          lane_i,
  input  logic          grant_i,
  input  logic          ack_i,
  input  logic [15:0]   rdata_i,
  output logic          pend_o,
  output logic [23:0]   addr_o,
  output logic          valid_o,
  output logic [DW-1:0] dout_o
);

  logic          cs_q;
  logic          pend_q;
  logic          fly_q;
  logic          abort_q;
  logic          lane_q;
  logic          valid_q;
  logic [23:0]   addr_q;
  logic [DW-1:0] dout_q;

  logic          edge_s;
  logic          done_s;
  logic          hit_s;
  logic [15:0]   src_w;
  logic          src_lane;
  logic [7:0]    lo_sel;
  logic [DW-1:0] fetch_s;

  assign edge_s = cs_i & ~cs_q;
  // Data is only delivered if the select survived the whole fetch.
  assign done_s = ack_i & ~abort_q & cs_i;

`ifdef ROM_LINE_BUF_EN
  logic [22:0] tag_q;
  logic        tag_vld_q;
  logic [15:0] line_q;

  assign hit_s    = edge_s & tag_vld_q & (tag_q == addr_i[23:1]);
  assign src_w    = hit_s ? line_q : rdata_i;
  assign src_lane = hit_s ? lane_i : lane_q;

  // Remember the last completed word and its word address.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      line_q    <= '0;
    end else if (done_s) begin
      tag_q     <= addr_q[23:1];
      tag_vld_q <= 1'b1;
      line_q    <= rdata_i;
    end
  end
`else
  assign hit_s    = 1'b0;
  assign src_w    = rdata_i;
  assign src_lane = lane_q;
`endif

  assign lo_sel = src_lane ? src_w[15:8] : src_w[7:0];

  generate
    if (DW == 16) begin : g_word
      assign fetch_s = {src_w[15:8], lo_sel};
    end else begin : g_byte
      assign fetch_s = lo_sel;
    end
  endgenerate

  // Capture, pending/in-flight/abort tracking and the returned-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q    <= 1'b0;
      pend_q  <= 1'b0;
      fly_q   <= 1'b0;
      abort_q <= 1'b0;
      lane_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      cs_q <= cs_i;
      if (edge_s) begin
        addr_q <= addr_i;
        lane_q <= lane_i;
      end
      if (edge_s && !hit_s)       pend_q <= 1'b1;
      else if (grant_i || !cs_i)  pend_q <= 1'b0;
      if (grant_i)                fly_q <= 1'b1;
      else if (ack_i)             fly_q <= 1'b0;
      // A grant racing a dropping select is already abandoned.
      if (grant_i)                abort_q <= ~cs_i;
      else if (fly_q && !cs_i)    abort_q <= 1'b1;
      if (done_s || hit_s) begin
        valid_q <= 1'b1;
        dout_q  <= fetch_s;
      end else if (!cs_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign valid_o = valid_q;
  assign dout_o  = dout_q;

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares the SDRAM ROM read channel between 68K program fetch and Z80 sound
// fetch: address translation, round-robin arbiter FSM and bus mux.
// Optional per-requester line buffer enabled by ROM_LINE_BUF_EN.
//
// state   | meaning
// IDLE    | no fetch on the bus; grants a pending requester
// BUSY    | rom_req/rom_addr held for the granted requester until rom_ack
module rom_fetch_arbiter
  import snk68_rom_pkg::*;
#(
  parameter logic [23:0] ROM_BASE      = ROM_BASE_DEF,
  parameter logic [23:0] M68K_ROM2_OFS = M68K_ROM2_OFS_DEF,
  parameter logic [23:0] Z80_ROM_OFS   = Z80_ROM_OFS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_rom_cs,
  input  logic        m68k_rom_2_cs,
  input  logic [23:0] m68k_a,
  output logic [15:0] m68k_rom_dout,
  output logic        m68k_rom_valid,
  input  logic        z80_rom_cs,
  input  logic [15:0] z80_addr,
  output logic [7:0]  z80_rom_dout,
  output logic        z80_rom_valid,
  output logic        rom_req,
  output logic [23:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data
);

  logic        m_cs, m_pend, z_pend;
  logic        m_grant, z_grant, m_ack, z_ack;
  logic [23:0] m_xlat, z_xlat, m_addr, z_addr;
  logic        unused_m68k_a;

  state_e      state_q, state_d;
  req_e        last_q, last_d, gnt_q, gnt_d, pick;
  logic        rom_req_q, rom_req_d;
  logic [23:0] rom_addr_q, rom_addr_d;

  assign m_cs   = m68k_rom_cs | m68k_rom_2_cs;
  assign m_xlat = ROM_BASE + (m68k_rom_2_cs ? M68K_ROM2_OFS : 24'h000000)
                + {6'b0, m68k_a[17:1], 1'b0};
  assign z_xlat = ROM_BASE + Z80_ROM_OFS + {8'b0, z80_addr[15:1], 1'b0};
  assign unused_m68k_a = ^{m68k_a[23:18], m68k_a[0]};

  rom_req_port #(.DW(16)) u_m68k (
    .clk     (clk),
    .reset   (reset),
    .cs_i    (m_cs),
    .addr_i  (m_xlat),
    .lane_i  (1'b0),
    .grant_i (m_grant),
    .ack_i   (m_ack),
    .rdata_i (rom_data),
    .pend_o  (m_pend),
    .addr_o  (m_addr),
    .valid_o (m68k_rom_valid),
    .dout_o  (m68k_rom_dout)
  );

  rom_req_port #(.DW(8)) u_z80 (
    .clk     (clk),
    .reset   (reset),
    .cs_i    (z80_rom_cs),
    .addr_i  (z_xlat),
    .lane_i  (z80_addr[0]),
    .grant_i (z_grant),
    .ack_i   (z_ack),
    .rdata_i (rom_data),
    .pend_o  (z_pend),
    .addr_o  (z_addr),
    .valid_o (z80_rom_valid),
    .dout_o  (z80_rom_dout)
  );

  assign pick = rr_pick(m_pend, z_pend, last_q);

  // Arbiter next state: grant from IDLE, wait for ack in BUSY.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    m_grant    = 1'b0;
    z_grant    = 1'b0;
    m_ack      = 1'b0;
    z_ack      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_pend || z_pend) begin
          state_d    = ST_BUSY;
          gnt_d      = pick;
          last_d     = pick;
          rom_req_d  = 1'b1;
          rom_addr_d = (pick == REQ_Z80) ? z_addr : m_addr;
          m_grant    = (pick == REQ_M68K);
          z_grant    = (pick == REQ_Z80);
        end
      end
      ST_BUSY: begin
        if (rom_ack) begin
          state_d   = ST_IDLE;
          rom_req_d = 1'b0;
          m_ack     = (gnt_q == REQ_M68K);
          z_ack     = (gnt_q == REQ_Z80);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter registers; reset abandons any request on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= REQ_Z80;
      gnt_q      <= REQ_M68K;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign rom_req  = rom_req_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Testbench for rom_fetch_arbiter: directed scenarios plus randomized
// fetches checked against a transaction-level model of address map,
// round-robin order and returned data.
module tb_rom_fetch_arbiter;

  localparam int unsigned TB_ROM_BASE = 32'h000000;
  localparam int unsigned TB_ROM2_OFS = 32'h040000;
  localparam int unsigned TB_Z80_OFS  = 32'h080000;

  logic        clk = 1'b0;
  logic        reset;
  logic        m68k_rom_cs, m68k_rom_2_cs;
  logic [23:0] m68k_a;
  logic [15:0] m68k_rom_dout;
  logic        m68k_rom_valid;
  logic        z80_rom_cs;
  logic [15:0] z80_addr;
  logic [7:0]  z80_rom_dout;
  logic        z80_rom_valid;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;

  int checks = 0;
  int errors = 0;

  // Model state: who was granted last, and what each dout should hold.
  bit          last_z;
  logic [15:0] exp_m_dout;
  logic [7:0]  exp_z_dout;

  always #5 clk = ~clk;

  rom_fetch_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m68k_rom_cs    (m68k_rom_cs),
    .m68k_rom_2_cs  (m68k_rom_2_cs),
    .m68k_a         (m68k_a),
    .m68k_rom_dout  (m68k_rom_dout),
    .m68k_rom_valid (m68k_rom_valid),
    .z80_rom_cs     (z80_rom_cs),
    .z80_addr       (z80_addr),
    .z80_rom_dout   (z80_rom_dout),
    .z80_rom_valid  (z80_rom_valid),
    .rom_req        (rom_req),
    .rom_addr       (rom_addr),
    .rom_ack        (rom_ack),
    .rom_data       (rom_data)
  );

  function automatic logic [23:0] m_xlat(input logic [23:0] a, input logic r2);
    int unsigned off;
    off = a % 32'h40000;
    off = off - (off % 2);
    return 24'(TB_ROM_BASE + (r2 ? TB_ROM2_OFS : 0) + off);
  endfunction

  function automatic logic [23:0] z_xlat(input logic [15:0] za);
    int unsigned off;
    off = za;
    off = off - (off % 2);
    return 24'(TB_ROM_BASE + TB_Z80_OFS + off);
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    m68k_rom_cs   = 1'b0;
    m68k_rom_2_cs = 1'b0;
    z80_rom_cs    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    release_all();
    rom_ack = 1'b0;
    step();
    step();
    last_z     = 1'b1;
    exp_m_dout = '0;
    exp_z_dout = '0;
    check("rst rom_req", rom_req, 0);
    check("rst rom_addr", rom_addr, 0);
    check("rst m valid", m68k_rom_valid, 0);
    check("rst z valid", z80_rom_valid, 0);
    check("rst m dout", m68k_rom_dout, 0);
    check("rst z dout", z80_rom_dout, 0);
    reset = 1'b0;
  endtask

  // Wait for the next request, check it, hold it dly cycles, then ack with d.
  task automatic serve(input bit is_z, input logic [23:0] ea, input logic [15:0] d,
                       input int dly, input logic lane, input string tag);
    int n;
    n = 0;
    while (!rom_req && n < 20) begin
      step();
      n++;
    end
    check({tag, " req"}, rom_req, 1);
    check({tag, " addr"}, rom_addr, ea);
    for (int i = 0; i < dly; i++) begin
      step();
      check({tag, " hold req"}, rom_req, 1);
      check({tag, " hold addr"}, rom_addr, ea);
    end
    rom_ack  = 1'b1;
    rom_data = d;
    step();
    rom_ack  = 1'b0;
    rom_data = 16'($urandom);
    if (is_z) begin
      exp_z_dout = 8'((d >> (lane ? 8 : 0)) & 16'h00ff);
      check({tag, " z valid"}, z80_rom_valid, 1);
      check({tag, " z dout"}, z80_rom_dout, exp_z_dout);
    end else begin
      exp_m_dout = d;
      check({tag, " m valid"}, m68k_rom_valid, 1);
      check({tag, " m dout"}, m68k_rom_dout, exp_m_dout);
    end
    check({tag, " no req in ack cycle"}, rom_req, 0);
    last_z = is_z;
  endtask

  task automatic single(input bit is_z, input logic [23:0] a, input logic r2,
                        input logic [15:0] d, input int dly, input string tag);
    logic [23:0] ea;
    if (is_z) begin
      z80_addr   = a[15:0];
      z80_rom_cs = 1'b1;
      ea         = z_xlat(a[15:0]);
    end else begin
      m68k_a        = a;
      m68k_rom_cs   = ~r2;
      m68k_rom_2_cs = r2;
      ea            = m_xlat(a, r2);
    end
    step();
    check({tag, " req early"}, rom_req, 0);
    step();
    check({tag, " req at 2 clk"}, rom_req, 1);
    serve(is_z, ea, d, dly, a[0], tag);
    step();
    check({tag, " valid hold"}, is_z ? z80_rom_valid : m68k_rom_valid, 1);
    release_all();
    step();
    check({tag, " valid clear"}, is_z ? z80_rom_valid : m68k_rom_valid, 0);
    if (is_z) check({tag, " z dout kept"}, z80_rom_dout, exp_z_dout);
    else      check({tag, " m dout kept"}, m68k_rom_dout, exp_m_dout);
  endtask

  task automatic pair(input logic [23:0] ma, input logic r2, input logic [15:0] za,
                      input logic [15:0] dm, input logic [15:0] dz, input string tag);
    bit first_z;
    first_z       = ~last_z;
    m68k_a        = ma;
    m68k_rom_cs   = ~r2;
    m68k_rom_2_cs = r2;
    z80_addr      = za;
    z80_rom_cs    = 1'b1;
    step();
    check({tag, " req early"}, rom_req, 0);
    step();
    check({tag, " req at 2 clk"}, rom_req, 1);
    if (first_z) begin
      serve(1'b1, z_xlat(za), dz, $urandom_range(0, 2), za[0], {tag, " 1st z"});
      serve(1'b0, m_xlat(ma, r2), dm, $urandom_range(0, 2), 1'b0, {tag, " 2nd m"});
    end else begin
      serve(1'b0, m_xlat(ma, r2), dm, $urandom_range(0, 2), 1'b0, {tag, " 1st m"});
      serve(1'b1, z_xlat(za), dz, $urandom_range(0, 2), za[0], {tag, " 2nd z"});
    end
    release_all();
    step();
    check({tag, " m valid clear"}, m68k_rom_valid, 0);
    check({tag, " z valid clear"}, z80_rom_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    m68k_rom_cs   = 1'b0;
    m68k_rom_2_cs = 1'b0;
    m68k_a        = '0;
    z80_rom_cs    = 1'b0;
    z80_addr      = '0;
    rom_ack       = 1'b0;
    rom_data      = '0;
    #1;
    do_reset();

    // Basic 68K fetch with ack three cycles after the request.
    single(1'b0, 24'h001234, 1'b0, 16'hBEEF, 3, "m68k basic");

`ifdef ROM_LINE_BUF_EN
    m68k_a      = 24'h001234;
    m68k_rom_cs = 1'b1;
    step();
    check("linebuf valid", m68k_rom_valid, 1);
    check("linebuf dout", m68k_rom_dout, 16'hBEEF);
    check("linebuf no req", rom_req, 0);
    step();
    check("linebuf no req later", rom_req, 0);
    release_all();
    step();
    do_reset();
`endif
    // Same address again must go to the bus.
    single(1'b0, 24'h001234, 1'b0, 16'hC0DE, 1, "m68k repeat");

    single(1'b0, 24'h300010, 1'b1, 16'h7E57, 0, "rom2");
    single(1'b1, 24'h000123, 1'b0, 16'hA55A, 2, "z80 lane1");
    check("z80 lane1 byte", z80_rom_dout, 8'hA5);
    single(1'b1, 24'h000456, 1'b0, 16'h3CC3, 1, "z80 lane0");
    single(1'b1, 24'h000123, 1'b0, 16'hA55A, 0, "z80 reload");

    // Contention right after reset: 68K first, then Z80 first after a 68K fetch.
    do_reset();
    pair(24'h012340, 1'b0, 16'h2222, 16'h1357, 16'h2468, "tie after reset");
    single(1'b0, 24'h000100, 1'b0, 16'h0F0F, 0, "m68k between ties");
    pair(24'h020000, 1'b1, 16'h3333, 16'h9ABC, 16'hDEF0, "tie z first");

    // Pending Z80 request dropped before grant is never issued.
    m68k_a      = 24'h001000;
    m68k_rom_cs = 1'b1;
    step();
    step();
    z80_addr   = 16'h0800;
    z80_rom_cs = 1'b1;
    step();
    z80_rom_cs = 1'b0;
    step();
    serve(1'b0, m_xlat(24'h001000, 1'b0), 16'h4444, 0, 1'b0, "cancel m");
    for (int i = 0; i < 3; i++) begin
      step();
      check("cancel no req", rom_req, 0);
      check("cancel z valid", z80_rom_valid, 0);
    end
    release_all();
    step();

    // Z80 drops its select while its fetch is on the bus; 68K waits behind it.
    z80_addr   = 16'h0AB1;
    z80_rom_cs = 1'b1;
    step();
    step();
    check("abort z req", rom_req, 1);
    check("abort z addr", rom_addr, z_xlat(16'h0AB1));
    last_z = 1'b1;
    step();
    z80_rom_cs  = 1'b0;
    m68k_a      = 24'h0055AA;
    m68k_rom_cs = 1'b1;
    step();
    check("abort req held", rom_req, 1);
    check("abort addr held", rom_addr, z_xlat(16'h0AB1));
    rom_ack  = 1'b1;
    rom_data = 16'h1111;
    step();
    rom_ack = 1'b0;
    check("abort z valid", z80_rom_valid, 0);
    check("abort z dout", z80_rom_dout, exp_z_dout);
    check("abort req drop", rom_req, 0);
    serve(1'b0, m_xlat(24'h0055AA, 1'b0), 16'h5A5A, 1, 1'b0, "after abort m");
    release_all();
    step();

    // Randomized mix of single fetches and simultaneous selects.
    for (int it = 0; it < 30; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)
        single(1'b0, 24'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 3), "rand m");
      else if (kind == 1)
        single(1'b1, 24'($urandom_range(0, 16'hEFFF)), 1'b0, 16'($urandom), $urandom_range(0, 3), "rand z");
      else
        pair(24'($urandom), 1'($urandom), 16'($urandom_range(0, 16'hEFFF)),
             16'($urandom), 16'($urandom), "rand tie");
    end

    // Reset while the bus is busy; a late ack must not produce data.
    m68k_a      = 24'h00ABCD;
    m68k_rom_cs = 1'b1;
    step();
    step();
    check("midrst req", rom_req, 1);
    step();
    reset = 1'b1;
    release_all();
    step();
    last_z     = 1'b1;
    exp_m_dout = '0;
    exp_z_dout = '0;
    check("midrst req drop", rom_req, 0);
    check("midrst m valid", m68k_rom_valid, 0);
    check("midrst z valid", z80_rom_valid, 0);
    check("midrst addr", rom_addr, 0);
    reset = 1'b0;
    step();
    rom_ack  = 1'b1;
    rom_data = 16'hFFFF;
    step();
    rom_ack = 1'b0;
    step();
    check("late ack req", rom_req, 0);
    check("late ack m valid", m68k_rom_valid, 0);
    check("late ack z valid", z80_rom_valid, 0);
    check("late ack m dout", m68k_rom_dout, exp_m_dout);

    // Arbiter still works after the abandoned transaction.
    single(1'b1, 24'h000777, 1'b0, 16'h8001, 1, "post reset z");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
